rv32im_bus_arbiter: RTL and testbench
=====================================

Name: rv32im_bus_arbiter

Overview:
- Shared-bus arbiter for the rv32im core's single Wishbone-classic master port.
- Grants the bus among four requesters: 0 = memory stage, 1 = instruction prefetch, 2 = external/DMA, 3 = debug.
- Uses fixed priority with hold-until-release and parks on a default master, so prefetch restarts with zero latency.
- Includes a bus watchdog that aborts hung transactions with an error back to the owning requester.

Parameters:
- XLEN, 32, data width; address width is XLEN-2 (word addressed).
- DEFAULT_MASTER, 4'b0010, one-hot grant held at reset and when idle.
- TIMEOUT_CYCLES, 255, cycles without ack/err before abort; 0 disables the watchdog.
- TIMEOUT_BITS, 8, width of the watchdog counter; must satisfy TIMEOUT_CYCLES < 2^TIMEOUT_BITS.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- m_stb_i  in  4  per-requester strobe / request
- m_we_i  in  4  per-requester write enable
- m_adr_i  in  4*(XLEN-2)  packed addresses; requester n in bits [n*(XLEN-2) +: XLEN-2]
- m_dat_i  in  4*XLEN  packed write data
- m_sel_i  in  16  packed byte selects, 4 bits per requester
- m_ack_o  out  4  ack, routed only to the granted requester
- m_err_o  out  4  err, routed only to the granted requester (slave err or watchdog)
- m_dat_o  out  XLEN  read data, broadcast to all requesters
- s_stb_o, s_we_o  out  1 each  to slave bus
- s_adr_o  out  XLEN-2  to slave bus
- s_dat_o  out  XLEN  to slave bus
- s_sel_o  out  4  to slave bus
- s_dat_i  in  XLEN  from slave bus
- s_ack_i, s_err_i  in  1 each  from slave bus
- grant_o  out  4  registered one-hot grant
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- grant_q is a one-hot register; reset value DEFAULT_MASTER. grant_o = grant_q.
- Slave-side outputs are a combinational mux of the granted requester's signals.
  - s_stb_o = m_stb_i[g] & ~abort.
  - s_we_o and s_sel_o are the granted values, forced to 0 when s_stb_o is 0.
- m_dat_o = s_dat_i unconditionally.
- m_ack_o[g] = s_ack_i & s_stb_o. m_err_o[g] = (s_err_i & s_stb_o) | abort. Non-granted bits are always 0.
- Arbitration is evaluated every cycle, registered, and effective the next cycle:
  - If m_stb_i[g] = 1: hold the grant. There is no preemption, even by requester 0.
  - Else if any m_stb_i bit is set: grant the lowest index set (0 > 1 > 2 > 3).
  - Else: grant DEFAULT_MASTER.
- Latency:
  - Parked requester: zero cycles (its stb reaches the slave the same cycle).
  - Any other requester: exactly one cycle from stb rise to s_stb_o, provided the current owner is idle.
- Requester contract: the owner deasserts stb the cycle after ack/err. A requester holding stb continuously keeps the bus indefinitely; this is the accepted policy.
- Watchdog, when TIMEOUT_CYCLES > 0:
  - Counter wd increments each cycle with s_stb_o=1 and s_ack_i=0 and s_err_i=0.
  - wd clears when s_stb_o=0, on ack/err, or on a grant change.
  - abort = (wd == TIMEOUT_CYCLES). In that cycle: s_stb_o is forced low, m_err_o[g]=1, timeout_o=1, and wd clears next cycle.
  - A slave ack/err arriving in the same cycle wd reaches the limit wins; no abort is raised.
- When TIMEOUT_CYCLES = 0, wd holds at 0 and abort is never raised.
- Reset while a transaction is in progress:
  - Next cycle: grant = DEFAULT_MASTER, wd = 0, timeout_o = 0.
  - In the reset cycle itself, m_ack_o and m_err_o are still combinational passthroughs; the bench must ignore them.
- Grants are one-hot at all times; grant_q never becomes zero or multi-hot.

Test Plan:
- Parked prefetch: after reset only m_stb_i=4'b0010 → s_stb_o=1 in the same cycle; s_adr_o equals requester 1's address; the ack is seen only on m_ack_o[1].
- Priority on idle bus:
  - Stimulus: grant=0010, requester 1 idle, m_stb_i=4'b1100 raised together.
  - Required: next cycle grant_o=0100 (requester 2, the lowest set index), s_stb_o=1; after requester 2 releases, grant_o=1000 one cycle later.
- No preemption:
  - Stimulus: requester 1 holds stb awaiting ack for 5 cycles; requester 0 raises stb at cycle 2.
  - Required: grant stays 0010 until the cycle after requester 1 drops stb, then becomes 0001.
- Watchdog with TIMEOUT_CYCLES=4: requester 2 granted, slave never acks → on the 5th strobe cycle (wd=4) m_err_o=0100, timeout_o=1, s_stb_o=0; next cycle wd=0.
- Ack at the limit: same setup, with s_ack_i=1 exactly when wd=4 → m_ack_o[2]=1, m_err_o=0, timeout_o=0.
- Reset mid-transfer: requester 3 granted with stb high; pulse reset_i for one cycle → next cycle grant_o=0010, timeout_o=0, and the watchdog restarts from 0.

Source files
------------

// File: rtl/rv32im_bus_arbiter.sv
// rtl/rv32im_bus_arbiter.sv - fixed-priority Wishbone-classic arbiter for four requesters
// The grant is held until the owner releases it and parks on DEFAULT_MASTER; a watchdog aborts hung cycles.
module rv32im_bus_arbiter #(
  parameter int         XLEN           = 32,
  parameter logic [3:0] DEFAULT_MASTER = 4'b0010,
  parameter int         TIMEOUT_CYCLES = 255,
  parameter int         TIMEOUT_BITS   = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [3:0]            m_stb_i,
  input  logic [3:0]            m_we_i,
  input  logic [4*(XLEN-2)-1:0] m_adr_i,
  input  logic [4*XLEN-1:0]     m_dat_i,
  input  logic [15:0]           m_sel_i,
  output logic [3:0]            m_ack_o,
  output logic [3:0]            m_err_o,
  output logic [XLEN-1:0]       m_dat_o,
  output logic                  s_stb_o,
  output logic                  s_we_o,
  output logic [XLEN-3:0]       s_adr_o,
  output logic [XLEN-1:0]       s_dat_o,
  output logic [3:0]            s_sel_o,
  input  logic [XLEN-1:0]       s_dat_i,
  input  logic                  s_ack_i,
  input  logic                  s_err_i,
  output logic [3:0]            grant_o,
  output logic                  timeout_o
);

  localparam int AW = XLEN - 2;
  localparam logic [TIMEOUT_BITS-1:0] WD_LIMIT = TIMEOUT_BITS'(TIMEOUT_CYCLES);

  logic [3:0]              grant_q;
  logic [3:0]              grant_d;
  logic [TIMEOUT_BITS-1:0] wd_q;
  logic [1:0]              gidx;
  logic                    stb_g;
  logic                    limit_hit;
  logic                    abort;

  always_comb begin
    gidx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (grant_q[i]) gidx = 2'(i);
    end
  end

  assign stb_g     = m_stb_i[gidx];
  assign limit_hit = (TIMEOUT_CYCLES != 0) && (wd_q == WD_LIMIT);
  // A slave response landing on the limit cycle takes precedence over the abort.
  assign abort     = limit_hit & stb_g & ~s_ack_i & ~s_err_i;

  assign s_stb_o   = stb_g & ~abort;
  assign s_we_o    = s_stb_o & m_we_i[gidx];
  assign s_sel_o   = s_stb_o ? m_sel_i[int'(gidx)*4 +: 4] : 4'b0000;
  assign s_adr_o   = m_adr_i[int'(gidx)*AW +: AW];
  assign s_dat_o   = m_dat_i[int'(gidx)*XLEN +: XLEN];
  assign m_dat_o   = s_dat_i;

  assign m_ack_o   = grant_q & {4{s_ack_i & s_stb_o}};
  assign m_err_o   = grant_q & {4{(s_err_i & s_stb_o) | abort}};
  assign timeout_o = abort;
  assign grant_o   = grant_q;

  always_comb begin
    if (|(m_stb_i & grant_q)) begin
      grant_d = grant_q;
    end else if (|m_stb_i) begin
      // Isolate the lowest set request bit.
      grant_d = m_stb_i & (~m_stb_i + 4'd1);
    end else begin
      grant_d = DEFAULT_MASTER;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      grant_q <= DEFAULT_MASTER;
      wd_q    <= '0;
    end else begin
      grant_q <= grant_d;
      if ((TIMEOUT_CYCLES == 0) || (grant_d != grant_q) || abort ||
          !s_stb_o || s_ack_i || s_err_i) begin
        wd_q <= '0;
      end else begin
        wd_q <= wd_q + TIMEOUT_BITS'(1);
      end
    end
  end

endmodule

// File: tb/tb_rv32im_bus_arbiter.sv
// tb/tb_rv32im_bus_arbiter.sv - directed vector bench for rv32im_bus_arbiter
// Each table row is one clock cycle of requester/slave stimulus with the outputs expected in that cycle.
module tb_rv32im_bus_arbiter;

  localparam int XLEN = 32;
  localparam int AW   = XLEN - 2;

  logic                  clk_i = 1'b0;
  logic                  reset_i;
  logic [3:0]            m_stb_i;
  logic [3:0]            m_we_i;
  logic [4*AW-1:0]       m_adr_i;
  logic [4*XLEN-1:0]     m_dat_i;
  logic [15:0]           m_sel_i;
  logic [3:0]            m_ack_o;
  logic [3:0]            m_err_o;
  logic [XLEN-1:0]       m_dat_o;
  logic                  s_stb_o;
  logic                  s_we_o;
  logic [AW-1:0]         s_adr_o;
  logic [XLEN-1:0]       s_dat_o;
  logic [3:0]            s_sel_o;
  logic [XLEN-1:0]       s_dat_i;
  logic                  s_ack_i;
  logic                  s_err_i;
  logic [3:0]            grant_o;
  logic                  timeout_o;

  rv32im_bus_arbiter #(
    .XLEN(XLEN), .DEFAULT_MASTER(4'b0010), .TIMEOUT_CYCLES(4), .TIMEOUT_BITS(3)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_ack_o(m_ack_o),
    .m_err_o(m_err_o), .m_dat_o(m_dat_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic       rst;
    logic [3:0] stb;
    logic       ack;
    logic       err;
    logic [3:0] grant;
    logic       sstb;
    logic [3:0] mack;
    logic [3:0] merr;
    logic       tmo;
  } vec_t;

  vec_t        vecs[$];
  logic [AW-1:0]   adr_tab[4];
  logic [XLEN-1:0] dat_tab[4];
  logic [3:0]      sel_tab[4];
  logic [3:0]      we_pat;
  int              vectors;
  int              miscompares;

  function automatic void add(input logic rst, input logic [3:0] stb, input logic ack,
                              input logic err, input logic [3:0] grant, input logic sstb,
                              input logic [3:0] mack, input logic [3:0] merr, input logic tmo);
    vec_t v;
    v.rst = rst; v.stb = stb; v.ack = ack; v.err = err; v.grant = grant;
    v.sstb = sstb; v.mack = mack; v.merr = merr; v.tmo = tmo;
    vecs.push_back(v);
  endfunction

  function automatic int idx_of(input logic [3:0] g);
    case (g)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic check(input string name, input int row, input logic [63:0] act,
                       input logic [63:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
    end
  endtask

  initial begin
    int gi;
    vectors = 0;
    miscompares = 0;
    we_pat = 4'b1010;
    for (int n = 0; n < 4; n++) begin
      adr_tab[n] = AW'(32'h0000_1000 + n * 16);
      dat_tab[n] = 32'hDEAD_0000 + n;
    end
    sel_tab[0] = 4'b0001; sel_tab[1] = 4'b0011; sel_tab[2] = 4'b1100; sel_tab[3] = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      m_adr_i[n*AW +: AW]     = adr_tab[n];
      m_dat_i[n*XLEN +: XLEN] = dat_tab[n];
      m_sel_i[n*4 +: 4]       = sel_tab[n];
    end
    m_we_i = we_pat;

    // Parked prefetch, zero latency
    add(0, 4'b0010, 0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, 1, 0, 4'b0010, 1, 4'b0010, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    // Priority on idle bus
    add(0, 4'b1100, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1100, 0, 0, 4'b0100, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b1100, 1, 0, 4'b0100, 1, 4'b0100, 4'b0000, 0);
    add(0, 4'b1000, 0, 0, 4'b0100, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1000, 1, 0, 4'b1000, 1, 4'b1000, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'b1000, 0, 4'b0000, 4'b0000, 0);
    // No preemption; ack arrives on the limit cycle and wins
    add(0, 4'b0010, 0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0010, 0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0011, 1, 0, 4'b0010, 1, 4'b0010, 4'b0000, 0);
    add(0, 4'b0001, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0001, 1, 0, 4'b0001, 1, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0);
    // Watchdog abort twice in a row proves the counter restarts from zero
    add(0, 4'b0100, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) add(0, 4'b0100, 0, 0, 4'b0100, 1, 4'b0000, 4'b0000, 0);
      add(0, 4'b0100, 0, 0, 4'b0100, 0, 4'b0000, 4'b0100, 1);
    end
    add(0, 4'b0000, 0, 0, 4'b0100, 0, 4'b0000, 4'b0000, 0);
    // Ack exactly at the limit
    add(0, 4'b0100, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 4; k++) add(0, 4'b0100, 0, 0, 4'b0100, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b0100, 1, 0, 4'b0100, 1, 4'b0100, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'b0100, 0, 4'b0000, 4'b0000, 0);
    // Slave err passthrough, then parked owner wins over requester 0
    add(0, 4'b0010, 0, 1, 4'b0010, 1, 4'b0000, 4'b0010, 0);
    add(0, 4'b0000, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1111, 0, 0, 4'b0010, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b1101, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'b0001, 0, 4'b0000, 4'b0000, 0);
    // Reset mid-transfer on requester 3
    add(0, 4'b1000, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1000, 0, 0, 4'b1000, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b1000, 0, 0, 4'b1000, 1, 4'b0000, 4'b0000, 0);
    add(1, 4'b1000, 0, 0, 4'b1000, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b1000, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    for (int k = 0; k < 4; k++) add(0, 4'b1000, 0, 0, 4'b1000, 1, 4'b0000, 4'b0000, 0);
    add(0, 4'b1000, 0, 0, 4'b1000, 0, 4'b0000, 4'b1000, 1);
    add(0, 4'b0000, 0, 0, 4'b1000, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b0000, 0, 0, 4'b0010, 0, 4'b0000, 4'b0000, 0);

    reset_i = 1'b1;
    m_stb_i = 4'b0000;
    s_ack_i = 1'b0;
    s_err_i = 1'b0;
    s_dat_i = '0;
    repeat (2) @(posedge clk_i);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      reset_i = vecs[i].rst;
      m_stb_i = vecs[i].stb;
      s_ack_i = vecs[i].ack;
      s_err_i = vecs[i].err;
      s_dat_i = $urandom;
      @(negedge clk_i);
      vectors++;
      gi = idx_of(vecs[i].grant);
      check("grant_o", i, 64'(grant_o), 64'(vecs[i].grant));
      check("s_stb_o", i, 64'(s_stb_o), 64'(vecs[i].sstb));
      check("s_we_o", i, 64'(s_we_o), 64'(vecs[i].sstb & we_pat[gi]));
      check("s_sel_o", i, 64'(s_sel_o), 64'(vecs[i].sstb ? sel_tab[gi] : 4'b0000));
      check("s_adr_o", i, 64'(s_adr_o), 64'(adr_tab[gi]));
      check("s_dat_o", i, 64'(s_dat_o), 64'(dat_tab[gi]));
      check("m_dat_o", i, 64'(m_dat_o), 64'(s_dat_i));
      check("timeout_o", i, 64'(timeout_o), 64'(vecs[i].tmo));
      if (!vecs[i].rst) begin
        check("m_ack_o", i, 64'(m_ack_o), 64'(vecs[i].mack));
        check("m_err_o", i, 64'(m_err_o), 64'(vecs[i].merr));
      end
      @(posedge clk_i);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
